// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-file access path:
// FSM encoding, register map addresses and default address limits.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [15:0] MOTOR_SPEED = 16'd0;
    localparam logic [15:0] PARK        = 16'd2;
    localparam logic [15:0] BENDING     = 16'd4;
    localparam logic [15:0] FAN         = 16'd6;
    localparam logic [15:0] FAULT       = 16'd8;
    localparam logic [15:0] READY       = 16'd10;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_MAX_ADDR    = 10;
    localparam int DEF_WR_MAX_ADDR = 4;
    localparam int RD_LAT_MAX      = 4;

endpackage

// File: rtl/spi_reg_arb_if.sv
// Request/response bundle for the two requesters plus the register-file port.
// slave = the arbiter side, master = requesters and register file.
interface spi_reg_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [1:0]          i_req_valid;
    logic [1:0]          o_req_ready;
    logic [1:0]          i_req_wr;
    logic [2*ADDR_W-1:0] i_req_addr;
    logic [2*DATA_W-1:0] i_req_wdata;
    logic [1:0]          o_rsp_valid;
    logic [DATA_W-1:0]   o_rsp_rdata;
    logic                o_rsp_err;
    logic [ADDR_W-1:0]   o_addr;
    logic [DATA_W-1:0]   o_wdata;
    logic                o_wr;
    logic [DATA_W-1:0]   i_rdata;

    modport slave (
        input  i_req_valid, i_req_wr, i_req_addr, i_req_wdata, i_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_addr, o_wdata, o_wr
    );

    modport master (
        output i_req_valid, i_req_wr, i_req_addr, i_req_wdata, i_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_addr, o_wdata, o_wr
    );
endinterface

// File: rtl/spi_reg_arb_rr_arb2.sv
// Two-way round-robin grant; combinational grant, pointer moves on accept.
// Zero latency; grants nothing while en is low, so requesters simply hold valid.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       accept
);
    logic last_gnt;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_gnt ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    assign accept = |gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= gnt[1];
        end
    end
endmodule

// File: rtl/spi_reg_arb.sv
// Arbitrates two requesters onto the register-file port and returns one response pulse each.
// Error 1 cycle, write 2, read 2+RD_LAT after accept; ready only in IDLE, so requesters hold valid.
module spi_reg_arb
    import spi_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RD_LAT      = 1,
    parameter int MAX_ADDR    = DEF_MAX_ADDR,
    parameter int WR_MAX_ADDR = DEF_WR_MAX_ADDR
) (
    input  logic         clk,
    input  logic         rst,
    spi_reg_arb_if.slave bus
);
    localparam int CNT_W = $clog2(RD_LAT_MAX);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              port_q, port_d;
    logic              wr_q, wr_d;

    logic [1:0]        gnt;
    logic              accept;
    logic              sel;
    logic              sel_wr;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_stb_q, wr_stb_d;
    logic              rsp_err_q, rsp_err_d;
    logic [1:0]        rsp_vld_q, rsp_vld_d;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == IDLE),
        .req    (bus.i_req_valid),
        .gnt    (gnt),
        .accept (accept)
    );

    assign bus.o_req_ready = gnt;

    assign sel       = gnt[1];
    assign sel_wr    = bus.i_req_wr[sel];
    assign sel_addr  = sel ? bus.i_req_addr[2*ADDR_W-1:ADDR_W] : bus.i_req_addr[ADDR_W-1:0];
    assign sel_wdata = sel ? bus.i_req_wdata[2*DATA_W-1:DATA_W] : bus.i_req_wdata[DATA_W-1:0];
    assign sel_err   = sel_addr[0]
                     | (sel_addr > ADDR_W'(MAX_ADDR))
                     | (sel_wr & (sel_addr > ADDR_W'(WR_MAX_ADDR)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            port_q     <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            port_q     <= port_d;
            wr_q       <= wr_d;
        end
    end

    // Illegal requests skip the register port and answer straight away.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        port_d     = port_q;
        wr_d       = wr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    port_d  = sel;
                    wr_d    = sel_wr;
                    state_d = sel_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d = RESP;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = CNT_W'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, looking one state ahead.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_stb_d  = 1'b0;
        rdata_d   = '0;
        rsp_vld_d = 2'b00;
        rsp_err_d = 1'b0;
        if (state_q == IDLE && accept && !sel_err) begin
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
            wr_stb_d = sel_wr;
        end
        if (state_q == WAIT && wait_cnt_q == '0) begin
            rdata_d = bus.i_rdata;
        end
        if (state_d == RESP) begin
            rsp_vld_d = port_d ? 2'b10 : 2'b01;
            rsp_err_d = (state_q == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wr_stb_q  <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_vld_q <= 2'b00;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wr_stb_q  <= wr_stb_d;
            rsp_err_q <= rsp_err_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign bus.o_addr      = addr_q;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_wr        = wr_stb_q;
    assign bus.o_rsp_valid = rsp_vld_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_rsp_rdata = rdata_q;
endmodule

// File: tb/tb_spi_reg_arb.sv
// Drives two arbiter instances (read latency 1 and 3) against a request-level model
// of legality, latency, response routing and register contents.
module tb_spi_reg_arb;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_arb_if #(.ADDR_W(16), .DATA_W(16)) if1 ();
    spi_reg_arb_if #(.ADDR_W(16), .DATA_W(16)) if3 ();

    spi_reg_arb #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    spi_reg_arb #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    logic [1:0]  vld [2];
    logic [1:0]  wrv [2];
    logic [15:0] addr [2][2];
    logic [15:0] wd [2][2];

    assign if1.i_req_valid = vld[0];
    assign if1.i_req_wr    = wrv[0];
    assign if1.i_req_addr  = {addr[0][1], addr[0][0]};
    assign if1.i_req_wdata = {wd[0][1], wd[0][0]};
    assign if3.i_req_valid = vld[1];
    assign if3.i_req_wr    = wrv[1];
    assign if3.i_req_addr  = {addr[1][1], addr[1][0]};
    assign if3.i_req_wdata = {wd[1][1], wd[1][0]};

    logic [1:0]  rdy [2];
    logic [1:0]  rspv [2];
    logic [15:0] rspd [2];
    logic [15:0] oaddr [2];
    logic [15:0] owd [2];
    logic        rspe [2];
    logic        owr [2];
    assign rdy[0] = if1.o_req_ready;  assign rdy[1] = if3.o_req_ready;
    assign rspv[0] = if1.o_rsp_valid; assign rspv[1] = if3.o_rsp_valid;
    assign rspd[0] = if1.o_rsp_rdata; assign rspd[1] = if3.o_rsp_rdata;
    assign rspe[0] = if1.o_rsp_err;   assign rspe[1] = if3.o_rsp_err;
    assign oaddr[0] = if1.o_addr;     assign oaddr[1] = if3.o_addr;
    assign owd[0] = if1.o_wdata;      assign owd[1] = if3.o_wdata;
    assign owr[0] = if1.o_wr;         assign owr[1] = if3.o_wr;

    // Register-file responders: preload port, write on strobe, fixed read pipeline.
    logic        ld;
    logic [5:0]  ld_a;
    logic [15:0] ld_v1, ld_v3;
    logic [15:0] rf1 [64];
    logic [15:0] rf3 [64];
    logic [15:0] rd1;
    logic [15:0] rd3 [3];
    always @(posedge clk) begin
        if (ld) begin
            rf1[ld_a] <= ld_v1;
            rf3[ld_a] <= ld_v3;
        end else begin
            if (if1.o_wr) rf1[if1.o_addr[5:0]] <= if1.o_wdata;
            if (if3.o_wr) rf3[if3.o_addr[5:0]] <= if3.o_wdata;
        end
        rd1    <= rf1[if1.o_addr[5:0]];
        rd3[0] <= rf3[if3.o_addr[5:0]];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign if1.i_rdata = rd1;
    assign if3.i_rdata = rd3[2];

    int          total = 0;
    int          bad = 0;
    int          mdl_last [2];
    logic [15:0] mdl_mem [2][8];
    logic [15:0] mdl_addr [2];
    logic [15:0] mdl_wd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_port(input int d);
        if (vld[d] == 2'b11) return 1 - mdl_last[d];
        return vld[d][1] ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mdl_last[d] = 1;
            mdl_addr[d] = 16'h0;
            mdl_wd[d]   = 16'h0;
        end
    endtask

    // One transaction: wait for grant, predict, then apply the port's next request fields.
    task automatic txn(input int d, input int rdlat, input bit nv, input bit nwr,
                       input logic [15:0] naddr, input logic [15:0] nwd);
        int          p, n, lat, exp_lat, pulses;
        bit          w, e, leak;
        logic [15:0] a, wv, exp_rd;
        p = exp_port(d);
        @(negedge clk);
        chk("idle_rsp", rspv[d], 0);
        n = 0;
        while (rdy[d] == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("grant", rdy[d], 32'(1 << p));
        if (rdy[d] == 2'b00) begin
            @(posedge clk);
            #1;
            return;
        end
        w  = wrv[d][p];
        a  = addr[d][p];
        wv = wd[d][p];
        e  = a[0] || (a > 16'd10) || (w && a > 16'd4);
        exp_lat = e ? 1 : (w ? 2 : 2 + rdlat);
        exp_rd  = (!e && !w) ? mdl_mem[d][a[3:1]] : 16'h0;
        if (!e) begin
            mdl_addr[d] = a;
            mdl_wd[d]   = wv;
            if (w) mdl_mem[d][a[3:1]] = wv;
        end
        mdl_last[d] = p;
        @(posedge clk);
        #1;
        vld[d][p]  = nv;
        wrv[d][p]  = nwr;
        addr[d][p] = naddr;
        wd[d][p]   = nwd;
        lat = 0;
        pulses = 0;
        leak = 1'b0;
        do begin
            lat++;
            @(negedge clk);
            if (owr[d]) begin
                pulses++;
                chk("wr_cycle", lat, 1);
                chk("wr_addr", oaddr[d], a);
                chk("wr_data", owd[d], wv);
            end
            if (rdy[d] != 2'b00) leak = 1'b1;
        end while (rspv[d] == 2'b00 && lat < 20);
        chk("rsp_port", rspv[d], 32'(1 << p));
        chk("rsp_lat", lat, exp_lat);
        chk("rsp_err", rspe[d], e);
        chk("rsp_rdata", rspd[d], exp_rd);
        chk("wr_pulses", pulses, (!e && w) ? 1 : 0);
        chk("ready_busy", leak, 0);
        chk("addr_hold", oaddr[d], mdl_addr[d]);
        chk("wdata_hold", owd[d], mdl_wd[d]);
        @(posedge clk);
        #1;
    endtask

    task automatic single(input int d, input int rdlat, input int p, input bit w,
                          input logic [15:0] a, input logic [15:0] v);
        vld[d][p]  = 1'b1;
        wrv[d][p]  = w;
        addr[d][p] = a;
        wd[d][p]   = v;
        txn(d, rdlat, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int done [2];
        int p, pulses;
        rst = 1'b1;
        ld  = 1'b0;
        ld_a = '0;
        ld_v1 = '0;
        ld_v3 = '0;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 2'b00;
            wrv[d] = 2'b00;
            for (int q = 0; q < 2; q++) begin
                addr[d][q] = 16'h0;
                wd[d][q]   = 16'h0;
            end
        end
        model_reset();

        @(negedge clk);
        chk("rst_ready", rdy[0], 0);
        chk("rst_rsp_valid", rspv[0], 0);
        chk("rst_rsp_rdata", rspd[0], 0);
        chk("rst_rsp_err", rspe[0], 0);
        chk("rst_addr", oaddr[0], 0);
        chk("rst_wdata", owd[0], 0);
        chk("rst_wr", owr[0], 0);

        for (int i = 0; i < 6; i++) begin
            ld    = 1'b1;
            ld_a  = 6'(2 * i);
            ld_v1 = 16'($urandom);
            ld_v3 = 16'($urandom);
            mdl_mem[0][i] = ld_v1;
            mdl_mem[1][i] = ld_v3;
            @(negedge clk);
        end
        ld  = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read back through the other port.
        single(0, 1, 0, 1'b1, MOTOR_SPEED, 16'h0234);
        single(0, 1, 1, 1'b0, MOTOR_SPEED, 16'h0);

        // Both ports hold valid for four reads each: strict alternation.
        done[0] = 0;
        done[1] = 0;
        vld[0] = 2'b11;
        wrv[0] = 2'b00;
        addr[0][0] = 16'(2 * $urandom_range(0, 5));
        addr[0][1] = 16'(2 * $urandom_range(0, 5));
        for (int t = 0; t < 8; t++) begin
            p = exp_port(0);
            chk("alt_order", p, t % 2);
            done[p]++;
            txn(0, 1, done[p] < 4, 1'b0, 16'(2 * $urandom_range(0, 5)), 16'($urandom));
        end

        // Address legality corners.
        single(0, 1, 0, 1'b1, FAULT, 16'hBEEF);
        single(0, 1, 1, 1'b0, 16'd3, 16'h0);
        single(0, 1, 0, 1'b0, 16'd12, 16'h0);
        single(0, 1, 1, 1'b0, READY, 16'h0);
        single(0, 1, 0, 1'b1, BENDING, 16'h1357);
        single(0, 1, 1, 1'b1, FAN, 16'h2468);

        for (int t = 0; t < 40; t++) begin
            single(0, 1, $urandom_range(0, 1), 1'($urandom),
                   16'($urandom_range(0, 13)), 16'($urandom));
        end

        // Reset during the wait phase of a read drops the response.
        vld[0][0]  = 1'b1;
        wrv[0][0]  = 1'b0;
        addr[0][0] = PARK;
        @(negedge clk);
        chk("rst_case_grant", rdy[0], 1);
        @(posedge clk);
        #1;
        vld[0][0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_addr", oaddr[0], 0);
        chk("midrst_wdata", owd[0], 0);
        chk("midrst_rdata", rspd[0], 0);
        chk("midrst_wr", owr[0], 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rspv[0] != 2'b00 || owr[0]) pulses++;
        end
        chk("midrst_no_rsp", pulses, 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        vld[0] = 2'b11;
        wrv[0] = 2'b00;
        addr[0][0] = PARK;
        addr[0][1] = FAULT;
        chk("post_rst_first", exp_port(0), 0);
        txn(0, 1, 1'b0, 1'b0, 16'h0, 16'h0);
        txn(0, 1, 1'b0, 1'b0, 16'h0, 16'h0);

        // Longer read latency: data only valid in the last wait cycle.
        single(1, 3, 0, 1'b0, PARK, 16'h0);
        single(1, 3, 0, 1'b0, FAN, 16'h0);
        single(1, 3, 1, 1'b1, BENDING, 16'hA5A5);
        single(1, 3, 0, 1'b0, BENDING, 16'h0);
        single(1, 3, 1, 1'b0, 16'd9, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_arb.md
Name: spi_reg_arb

Overview:
Two-requester access controller and sequencer for the SPI register file's single address/data port.
- Port 0 is the SPI slave frame decoder; port 1 is the auxiliary debug/host requester.
- Arbitrates round-robin, checks address legality, and drives the register-file write and read cycle.
- Absorbs the register file's one-cycle read latency and returns a single response pulse per accepted request.

Parameters:
ADDR_W, 16, address width of requests and register port
DATA_W, 16, data width
RD_LAT, 1, register-file read latency in cycles (range 1..4)
MAX_ADDR, 10, highest legal (even) register address
WR_MAX_ADDR, 4, highest writable address; addresses above it up to MAX_ADDR are read-only

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
i_req_valid  in  2  request valid, bit i = port i
o_req_ready  out  2  request accepted when valid&ready on the same edge
i_req_wr  in  2  1 = write, 0 = read
i_req_addr  in  2*ADDR_W  flattened, port i at [i*ADDR_W +: ADDR_W]
i_req_wdata  in  2*DATA_W  flattened write data
o_rsp_valid  out  2  one-cycle response pulse to the originating port
o_rsp_rdata  out  DATA_W  read data, shared, qualified by o_rsp_valid
o_rsp_err  out  1  error flag, qualified by o_rsp_valid
o_addr  out  ADDR_W  register-file address
o_wdata  out  DATA_W  register-file write data
o_wr  out  1  register-file write strobe
i_rdata  in  DATA_W  register-file read data

Behaviour:
- Reset (asynchronous, active-high):
  - State is IDLE.
  - o_addr, o_wdata, o_rsp_rdata are 0; o_wr, o_rsp_valid, o_rsp_err, o_req_ready are 0.
  - Round-robin pointer last_gnt = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - o_req_ready is combinational and one-hot: it goes to the port that is valid.
  - If both ports are valid, it goes to the port != last_gnt.
  - o_req_ready is never asserted outside IDLE.
- On accept:
  - Capture port id, wr, addr, wdata; last_gnt <= port.
  - err = addr[0] | (addr > MAX_ADDR) | (wr & addr > WR_MAX_ADDR).
  - err=1 -> RESP directly; the register port is not touched.
  - Otherwise -> ACCESS.
- ACCESS (1 cycle):
  - o_addr/o_wdata are driven from the captured registers.
  - o_wr = captured wr.
  - Write -> RESP; read -> WAIT.
- WAIT (RD_LAT cycles):
  - o_addr is held and o_wr = 0.
  - i_rdata is sampled at the end of the final WAIT cycle into o_rsp_rdata.
  - Then -> RESP.
- RESP (1 cycle):
  - o_rsp_valid[port] = 1; o_rsp_err = err.
  - o_rsp_rdata = sampled data on a good read, 0 on writes and errors.
  - Then -> IDLE.
- Latency:
  - Accept edge at cycle a.
  - Good write: RESP at a+2.
  - Good read: RESP at a+2+RD_LAT.
  - Error: RESP at a+1.
  - Next accept no earlier than the edge closing the cycle after RESP.
- o_wr is high for exactly one cycle per good write and never otherwise.
- o_addr and o_wdata keep their last values while idle.
- Request fields of the accepted port are sampled only at the accept edge; later changes are ignored.
- A port must hold valid until ready.
- Simultaneous valids: strict alternation while both stay valid; no port waits more than one transaction.
- Reset mid-transaction: outputs return to reset values immediately; the in-flight response is dropped and no partial write strobe is issued.
- Combinational paths: only o_req_ready may depend combinationally on inputs (i_req_valid); all other outputs are registered.

Decomposition:
- Shared package spi_pkg:
  - state typedef (IDLE/ACCESS/WAIT/RESP);
  - register address constants (MOTOR_SPEED=0, PARK=2, BENDING=4, FAN=6, FAULT=8, READY=10);
  - default MAX_ADDR/WR_MAX_ADDR.
- Sub-module rr_arb2: 2-way round-robin grant with last_gnt pointer, update on accept.

Test Plan:
- Port0 write addr 0 data 16'h0234 -> o_wr one cycle at a+1 with o_addr=0, o_wdata=16'h0234; o_rsp_valid[0] at a+2, err=0.
- Port1 read addr 0 after that write, i_rdata model returns 16'h0234 with 1-cycle latency -> o_rsp_valid[1] at a+3, o_rsp_rdata=16'h0234, o_wr never high.
- Both ports valid continuously for 4 reads each -> grant order 0,1,0,1,...; each response goes to the correct port bit.
- Error cases:
  - write addr 8 -> err=1, rdata=0, no o_wr, response at a+1;
  - read addr 3 -> err=1;
  - read addr 12 -> err=1;
  - read addr 10 -> err=0.
- RD_LAT=3 build, read addr 6 -> response at a+5 with data present on i_rdata in the third WAIT cycle.
- Assert rst during the WAIT of a read -> o_rsp_valid never pulses, state IDLE, and the next port0 request is granted first.
